// File: rtl/aes_seq_pkg.sv
// rtl/aes_seq_pkg.sv - shared state encoding, stage-select constants and round-count helper
package aes_seq_pkg;

   localparam int DATA_W_DEF = 128;

   typedef enum logic [5:0] {
      S_IDLE = 6'b000001,
      S_ARK  = 6'b000010,
      S_SBT  = 6'b000100,
      S_SHR  = 6'b001000,
      S_MXC  = 6'b010000,
      S_DONE = 6'b100000
   } state_t;

   // msg_sel bit order is {ARK, SBT, SHR, MXC}
   localparam logic [3:0] SEL_NONE = 4'b0000;
   localparam logic [3:0] SEL_ARK  = 4'b1000;
   localparam logic [3:0] SEL_SBT  = 4'b0100;
   localparam logic [3:0] SEL_SHR  = 4'b0010;
   localparam logic [3:0] SEL_MXC  = 4'b0001;

   function automatic int nr_for_keylen(input int key_len);
      case (key_len)
         128:     return 10;
         192:     return 12;
         256:     return 14;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// rtl/aes_round_sequencer_if.sv - host handshake and stage bus of the round sequencer; Err exists with AES_SEQ_WATCHDOG_EN
interface aes_round_sequencer_if #(
   parameter int DATA_W = 128,
   parameter int KSEL_W = 4
);
   logic              Start;
   logic [DATA_W-1:0] PT;
   logic              Busy;
   logic              Done;
   logic [DATA_W-1:0] CT;
   logic              En_ARK, En_SBT, En_SHR, En_MXC;
   logic              Rst_ARK, Rst_SBT, Rst_SHR, Rst_MXC;
   logic              Ry_ARK, Ry_SBT, Ry_SHR, Ry_MXC;
   logic [DATA_W-1:0] msg_in;
   logic [DATA_W-1:0] Tx_out;
   logic [3:0]        msg_sel;
   logic [KSEL_W-1:0] KeySel;
`ifdef AES_SEQ_WATCHDOG_EN
   logic              Err;
`endif

   modport master (
      input  Start, PT, Ry_ARK, Ry_SBT, Ry_SHR, Ry_MXC, msg_in,
      output Busy, Done, CT, En_ARK, En_SBT, En_SHR, En_MXC,
             Rst_ARK, Rst_SBT, Rst_SHR, Rst_MXC, Tx_out, msg_sel, KeySel
`ifdef AES_SEQ_WATCHDOG_EN
      , output Err
`endif
   );

   modport slave (
      output Start, PT, Ry_ARK, Ry_SBT, Ry_SHR, Ry_MXC, msg_in,
      input  Busy, Done, CT, En_ARK, En_SBT, En_SHR, En_MXC,
             Rst_ARK, Rst_SBT, Rst_SHR, Rst_MXC, Tx_out, msg_sel, KeySel
`ifdef AES_SEQ_WATCHDOG_EN
      , input Err
`endif
   );

endinterface

// File: rtl/aes_round_ctr.sv
// rtl/aes_round_ctr.sv - AES round counter with clear, increment and saturation at NR
module aes_round_ctr #(
   parameter int NR     = 10,
   parameter int KSEL_W = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              clear,
   input  logic              incr,
   output logic [KSEL_W-1:0] round,
   output logic              is_final
);

   assign is_final = (round == KSEL_W'(NR));

   always_ff @(posedge Clk) begin
      if (Rst || clear) begin
         round <= '0;
      end else if (incr && !is_final) begin
         round <= round + 1'b1;
      end
   end

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - AES encryption-round controller; AES_SEQ_WATCHDOG_EN adds a per-stage watchdog and Err
module aes_round_sequencer
   import aes_seq_pkg::*;
#(
   parameter int KEY_LEN = 128,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int KSEL_W  = 4
`ifdef AES_SEQ_WATCHDOG_EN
   ,
   parameter int WD_CYCLES = 255
`endif
) (
   input logic                   Clk,
   input logic                   Rst,
   aes_round_sequencer_if.master bus
);

   localparam int NR = nr_for_keylen(KEY_LEN);

   if (NR == 0) begin : g_bad_key_len
      $error("aes_round_sequencer: KEY_LEN must be 128, 192 or 256");
   end
   if (DATA_W != 128) begin : g_bad_data_w
      $error("aes_round_sequencer: DATA_W must be 128");
   end
   if ((2 ** KSEL_W) <= NR) begin : g_bad_ksel_w
      $error("aes_round_sequencer: KSEL_W too narrow for NR");
   end

   state_t            state, state_nxt;
   logic [DATA_W-1:0] tx_q, ct_q;
   logic [KSEL_W-1:0] round;
   logic              is_final, ry_act, stage_act, start_ok, wd_expired;

   assign start_ok  = (state == S_IDLE) && bus.Start;
   assign stage_act = state inside {S_ARK, S_SBT, S_SHR, S_MXC};
   assign ry_act    = |(bus.msg_sel & {bus.Ry_ARK, bus.Ry_SBT, bus.Ry_SHR, bus.Ry_MXC});

   aes_round_ctr #(.NR(NR), .KSEL_W(KSEL_W)) u_round_ctr (
      .Clk      (Clk),
      .Rst      (Rst),
      .clear    (start_ok),
      .incr     ((state == S_ARK) && ry_act && !is_final),
      .round    (round),
      .is_final (is_final)
   );

   always_ff @(posedge Clk) begin
      if (Rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.Start) state_nxt = S_ARK;
         S_ARK:   if (ry_act) state_nxt = is_final ? S_DONE : S_SBT;
         S_SBT:   if (ry_act) state_nxt = S_SHR;
         // the final round skips MixColumns
         S_SHR:   if (ry_act) state_nxt = is_final ? S_ARK : S_MXC;
         S_MXC:   if (ry_act) state_nxt = S_ARK;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (wd_expired) state_nxt = S_IDLE;
   end

   always_comb begin
      bus.msg_sel = SEL_NONE;
      case (state)
         S_ARK:   bus.msg_sel = SEL_ARK;
         S_SBT:   bus.msg_sel = SEL_SBT;
         S_SHR:   bus.msg_sel = SEL_SHR;
         S_MXC:   bus.msg_sel = SEL_MXC;
         default: bus.msg_sel = SEL_NONE;
      endcase
   end

   assign {bus.En_ARK, bus.En_SBT, bus.En_SHR, bus.En_MXC}     = bus.msg_sel;
   assign {bus.Rst_ARK, bus.Rst_SBT, bus.Rst_SHR, bus.Rst_MXC} = ~bus.msg_sel;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         tx_q <= '0;
         ct_q <= '0;
      end else begin
         if (start_ok)                tx_q <= bus.PT;
         else if (stage_act && ry_act) tx_q <= bus.msg_in;
         if ((state == S_ARK) && ry_act && is_final) ct_q <= bus.msg_in;
      end
   end

   assign bus.Tx_out = tx_q;
   assign bus.CT     = ct_q;
   assign bus.KeySel = round;
   assign bus.Busy   = (state != S_IDLE);
   assign bus.Done   = (state == S_DONE);

`ifdef AES_SEQ_WATCHDOG_EN
   localparam int WD_W = $clog2(WD_CYCLES + 1);

   if (WD_CYCLES < 1) begin : g_bad_wd
      $error("aes_round_sequencer: WD_CYCLES must be at least 1");
   end

   logic [WD_W-1:0] wd_cnt;
   logic            err_q;

   assign wd_expired = stage_act && !ry_act && (wd_cnt == WD_W'(WD_CYCLES - 1));

   // counts cycles spent in the current stage visit; any state change restarts it
   always_ff @(posedge Clk) begin
      if (Rst) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (!stage_act || (state_nxt != state)) wd_cnt <= '0;
         else                                     wd_cnt <= wd_cnt + 1'b1;
         if (wd_expired)    err_q <= 1'b1;
         else if (start_ok) err_q <= 1'b0;
      end
   end

   assign bus.Err = err_q;
`else
   assign wd_expired = 1'b0;
`endif

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Parametrised AES encryption-round controller.
- Sequences the AddRoundKey, SubBytes, ShiftRows and MixColumns stage modules over a key-length-dependent number of rounds.
- Uses a Start/Done handshake, per-stage enable/reset/ready handshakes and a shared 128-bit state bus.
- Sits between the top-level I/O wrapper and the four stage modules plus the key-schedule ROM (indexed by KeySel).

Parameters:
- KEY_LEN, 128, AES key length in bits: 128, 192 or 256. Any other value is an elaboration error.
- DATA_W, 128, state width in bits. Fixed at 128; exposed for bus typing only.
- KSEL_W, 4, KeySel width. Must satisfy 2**KSEL_W > NR.
- NR (derived, localparam), 10/12/14 for KEY_LEN 128/192/256.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- Start  in  1  request to encrypt PT; sampled only in IDLE
- PT  in  DATA_W  plaintext; captured on the accepted Start edge
- Busy  out  1  high from the Start-accept edge until the Done cycle ends
- Done  out  1  one-cycle pulse; CT is valid from this cycle on
- CT  out  DATA_W  ciphertext; held until the next accepted Start
- En_ARK / En_SBT / En_SHR / En_MXC  out  1 each  enable for the active stage
- Rst_ARK / Rst_SBT / Rst_SHR / Rst_MXC  out  1 each  high for every non-active stage
- Ry_ARK / Ry_SBT / Ry_SHR / Ry_MXC  in  1 each  stage result valid on msg_in
- msg_in  in  DATA_W  result bus from the active stage
- Tx_out  out  DATA_W  registered working state driven to the stages
- msg_sel  out  4  one-hot stage select {ARK,SBT,SHR,MXC}; 0 when no stage is active
- KeySel  out  KSEL_W  round-key index (0..NR)

Behaviour:
- States: IDLE, ARK, SBT, SHR, MXC, DONE. Encoding is one-hot.
- Reset (Rst=1 at a clock edge, from any state):
  - state=IDLE, round=0, Tx_out=0, CT=0, KeySel=0, msg_sel=0, Busy=0, Done=0.
  - All En_*=0, all Rst_*=1.
- IDLE:
  - All stages held in reset.
  - Start=1 at an edge → Tx_out<=PT, round<=0, KeySel<=0, go to ARK, Busy<=1.
- Stage states:
  - Only the matching En_x=1 and Rst_x=0; msg_sel is the matching one-hot; all other stages stay in reset.
  - Ry of the active stage sampled 1 → Tx_out<=msg_in and advance. Otherwise hold state and Tx_out.
  - Ry of inactive stages is ignored.
- Transitions:
  - ARK with round<NR → SBT, round<=round+1.
  - SBT → SHR.
  - SHR → MXC if round<NR; SHR → ARK if round==NR (final round skips MixColumns).
  - MXC → ARK.
  - ARK with round==NR → DONE, and CT<=msg_in on the same edge.
- KeySel always equals round.
- DONE lasts exactly one cycle with Done=1 and Busy=1, then returns to IDLE.
- Start outside IDLE (including in DONE) is ignored and is not queued.
- Stage count is 4·NR stage visits. With stages responding 1 cycle after entry, each visit takes 2 cycles: Done=1 in the cycle after edge 80/96/112 counted from the Start edge (NR=10/12/14).
- A round-counter increment past NR is impossible by construction. The round counter saturates at NR.

Optional Feature:
- Macro AES_SEQ_WATCHDOG_EN.
- With it:
  - Adds parameter WD_CYCLES (default 255) and output Err (1 bit).
  - A per-stage-visit counter clears on stage entry.
  - If the active Ry stays low for WD_CYCLES cycles → go to IDLE, Err<=1, Busy<=0, no Done, CT unchanged.
  - Err clears on the next accepted Start or on Rst.
- Without it: no Err port; the sequencer waits indefinitely.

Decomposition:
- Package aes_seq_pkg:
  - State enum and one-hot msg_sel constants.
  - Function nr_for_keylen(KEY_LEN).
  - DATA_W default.
- Sub-module aes_round_ctr:
  - Round counter with clear, increment and saturation at NR.
  - Outputs round, is_final (round==NR) and KeySel.

Test Plan:
1. KEY_LEN=128; FIPS-197 C.1 vector; stage models return the correct transforms with 1-cycle Ry → CT=69c4e0d86a7b0430d8cdb78070b4c55a, Done 80 cycles after Start, single pulse.
2. KEY_LEN=256; FIPS-197 C.3 vector → CT=8ea2b7ca516745bfeafc49904b496089, KeySel sweeps 0..14, MXC never entered while round==14.
3. Start pulsed at cycles 5, 20 and the DONE cycle during operation → ignored. Only one Done; CT stays equal to the first result.
4. Rst asserted during SHR of round 4 → next cycle IDLE, all Rst_*=1, Busy=0, msg_sel=0. A new Start completes correctly.
5. Ry_SBT held high while in ARK → no effect. Ry_ARK delayed 7 cycles in round 3 → state and Tx_out held, total latency +6.
6. AES_SEQ_WATCHDOG_EN, WD_CYCLES=16, Ry_MXC never asserted → Err=1 after 16 cycles in MXC, IDLE, no Done. Next Start clears Err.
